// File: rtl/pong_frame_renderer.sv
// ---------------------------------------------------------------------------
// pong_frame_renderer
//
// Pixel-generation and game-state stage that sits directly behind a 640x480
// VGA timing generator. Once per frame (on the falling edge of vsync, which
// lands in vertical blanking) it advances one ball and one player paddle.
// Every pixel clock it turns the generator's coordinates into a 12-bit
// colour, delaying the syncs by the same two cycles so they stay aligned.
//
// Ports
//   clk, rst_n             pixel clock, asynchronous active-low reset
//   hsync_in, vsync_in     active-low syncs from the timing generator
//   display_on             active-video flag from the timing generator
//   x_pos, y_pos           current pixel coordinates
//   btn_up, btn_down       asynchronous active-high player buttons
//   hsync_out, vsync_out   syncs delayed by two cycles
//   rgb_out                {R,G,B} 4 bits each, delayed by two cycles
//   score                  paddle hits since the last miss, saturating
//   miss                   one-cycle pulse when the ball leaves on the left
//   ball_x, ball_y         ball top-left corner
//   paddle_y               paddle top edge
// ---------------------------------------------------------------------------
module pong_frame_renderer #(
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PAD_X        = 16,
    parameter int unsigned PAD_W        = 8,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned PAD_SPEED    = 4,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        display_on,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [11:0] rgb_out,
    output logic [7:0]  score,
    output logic        miss,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  paddle_y
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    // All geometry is handled at 11 bits so that sums and differences near
    // the screen edges never wrap.
    localparam logic [10:0] BSZ         = 11'(BALL_SIZE);
    localparam logic [10:0] BSPD        = 11'(BALL_SPEED);
    localparam logic [10:0] PSPD        = 11'(PAD_SPEED);
    localparam logic [10:0] PX          = 11'(PAD_X);
    localparam logic [10:0] PH          = 11'(PAD_H);
    localparam logic [10:0] PAD_RIGHT   = 11'(PAD_X + PAD_W);
    localparam logic [10:0] BALL_X_MAX  = 11'(H_DISPLAY - BALL_SIZE);
    localparam logic [10:0] BALL_Y_MAX  = 11'(V_DISPLAY - BALL_SIZE);
    localparam logic [10:0] PAD_Y_MAX   = 11'(V_DISPLAY - PAD_H);
    localparam logic [10:0] BALL_X_INIT = 11'((H_DISPLAY - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y_INIT = 11'((V_DISPLAY - BALL_SIZE) / 2);
    localparam logic [10:0] PAD_Y_INIT  = 11'((V_DISPLAY - PAD_H) / 2);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic [11:0] RGB_BLANK  = 12'h000;
    localparam logic [11:0] RGB_BALL   = 12'hFFF;
    localparam logic [11:0] RGB_PADDLE = 12'h0F0;
    localparam logic [11:0] RGB_FIELD  = 12'h002;

    typedef enum logic {
        ST_SERVE = 1'b0,
        ST_PLAY  = 1'b1
    } state_e;

    // Button synchronizers and vsync edge detector
    logic btn_up_meta_q, btn_up_sync_q;
    logic btn_down_meta_q, btn_down_sync_q;
    logic vs_d_q;
    logic frame_tick;

    // Game state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic [9:0]       ball_x_q, ball_x_d;
    logic [9:0]       ball_y_q, ball_y_d;
    logic [9:0]       paddle_y_q, paddle_y_d;
    logic             dx_q, dx_d;
    logic             dy_q, dy_d;
    logic [7:0]       score_q, score_d;
    logic             miss_q, miss_d;

    // Pixel pipeline
    logic [9:0]  x1_q, y1_q;
    logic        de1_q, hs1_q, vs1_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, vs2_q;

    // 11-bit views of the current positions and their candidate moves
    logic [10:0] bx, by, py;
    logic [10:0] bx_right, bx_left, by_down, by_up, py_down, py_up;
    logic        pad_overlap;

    assign bx = {1'b0, ball_x_q};
    assign by = {1'b0, ball_y_q};
    assign py = {1'b0, paddle_y_q};

    assign bx_right = bx + BSPD;
    assign bx_left  = bx - BSPD;
    assign by_down  = by + BSPD;
    assign by_up    = by - BSPD;
    assign py_down  = py + PSPD;
    assign py_up    = py - PSPD;

    assign pad_overlap = ((by + BSZ) > py) && (by < (py + PH));

    // A tick fires only on a falling vsync edge, which always lands in
    // vertical blanking, so positions never change mid-frame.
    assign frame_tick = vs_d_q & ~vsync_in;

    // Two-flop synchronizers for the buttons plus the vsync delay register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_up_meta_q   <= 1'b0;
            btn_up_sync_q   <= 1'b0;
            btn_down_meta_q <= 1'b0;
            btn_down_sync_q <= 1'b0;
            vs_d_q          <= 1'b1;
        end else begin
            btn_up_meta_q   <= btn_up;
            btn_up_sync_q   <= btn_up_meta_q;
            btn_down_meta_q <= btn_down;
            btn_down_sync_q <= btn_down_meta_q;
            vs_d_q          <= vsync_in;
        end
    end

    // Next-state logic for the paddle, the ball and the serve/play FSM.
    // Nothing moves except on a frame tick. The x and y axes are evaluated
    // independently on the same tick so a corner reflects both directions;
    // a miss then overrides both coordinates with the centre position.
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        paddle_y_d  = paddle_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        score_d     = score_q;
        miss_d      = 1'b0;

        if (frame_tick) begin
            if (btn_up_sync_q && !btn_down_sync_q) begin
                paddle_y_d = (py >= PSPD) ? py_up[9:0] : 10'd0;
            end else if (btn_down_sync_q && !btn_up_sync_q) begin
                paddle_y_d = (py_down >= PAD_Y_MAX) ? PAD_Y_MAX[9:0] : py_down[9:0];
            end

            if (state_q == ST_SERVE) begin
                if (serve_cnt_q == SERVE_LAST) begin
                    state_d     = ST_PLAY;
                    serve_cnt_d = '0;
                end else begin
                    serve_cnt_d = serve_cnt_q + CNT_W'(1);
                end
            end else begin
                if (dy_q) begin
                    if (by_down >= BALL_Y_MAX) begin
                        ball_y_d = BALL_Y_MAX[9:0];
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = by_down[9:0];
                    end
                end else begin
                    if (by <= BSPD) begin
                        ball_y_d = 10'd0;
                        dy_d     = 1'b1;
                    end else begin
                        ball_y_d = by_up[9:0];
                    end
                end

                if (dx_q) begin
                    if (bx_right >= BALL_X_MAX) begin
                        ball_x_d = BALL_X_MAX[9:0];
                        dx_d     = 1'b0;
                    end else begin
                        ball_x_d = bx_right[9:0];
                    end
                end else if (bx >= (PAD_RIGHT + BSPD)) begin
                    ball_x_d = bx_left[9:0];
                end else if ((bx >= PAD_RIGHT) && pad_overlap) begin
                    // The ball is snapped onto the paddle face so the
                    // rebound always starts from the same plane.
                    ball_x_d = PAD_RIGHT[9:0];
                    dx_d     = 1'b1;
                    score_d  = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
                end else if (bx >= BSPD) begin
                    ball_x_d = bx_left[9:0];
                end else begin
                    miss_d      = 1'b1;
                    score_d     = 8'd0;
                    ball_x_d    = BALL_X_INIT[9:0];
                    ball_y_d    = BALL_Y_INIT[9:0];
                    dx_d        = 1'b1;
                    dy_d        = dy_q;
                    state_d     = ST_SERVE;
                    serve_cnt_d = '0;
                end
            end
        end
    end

    // Game-state registers, including the FSM state and the registered
    // score/miss outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SERVE;
            serve_cnt_q <= '0;
            ball_x_q    <= BALL_X_INIT[9:0];
            ball_y_q    <= BALL_Y_INIT[9:0];
            paddle_y_q  <= PAD_Y_INIT[9:0];
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            score_q     <= 8'd0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            paddle_y_q  <= paddle_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
        end
    end

    // Colour for the pixel held in stage 1. Ball wins over paddle; both use
    // half-open ranges so an object covers exactly its size in pixels.
    always_comb begin
        logic [10:0] x1;
        logic [10:0] y1;
        logic        in_ball;
        logic        in_pad;

        x1 = {1'b0, x1_q};
        y1 = {1'b0, y1_q};
        in_ball = (x1 >= bx) && (x1 < (bx + BSZ)) &&
                  (y1 >= by) && (y1 < (by + BSZ));
        in_pad  = (x1 >= PX) && (x1 < PAD_RIGHT) &&
                  (y1 >= py) && (y1 < (py + PH));

        rgb_d = RGB_FIELD;
        if (!de1_q) begin
            rgb_d = RGB_BLANK;
        end else if (in_ball) begin
            rgb_d = RGB_BALL;
        end else if (in_pad) begin
            rgb_d = RGB_PADDLE;
        end
    end

    // Two-stage pixel pipeline: stage 1 captures the generator outputs,
    // stage 2 registers the colour and carries the syncs alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q  <= 10'd0;
            y1_q  <= 10'd0;
            de1_q <= 1'b0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            rgb_q <= 12'd0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            x1_q  <= x_pos;
            y1_q  <= y_pos;
            de1_q <= display_on;
            hs1_q <= hsync_in;
            vs1_q <= vsync_in;
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign rgb_out   = rgb_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign paddle_y  = paddle_y_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// ---------------------------------------------------------------------------
// tb_pong_frame_renderer
//
// Scoreboard bench for pong_frame_renderer. Stimulus tasks drive short
// synthetic frames (a few cycles of vsync high, one cycle low) and pixel
// vectors, pushing hand-computed expectations tagged with the cycle on which
// they must appear. An independent monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_pong_frame_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsync_in, vsync_in, display_on;
    logic [9:0]  x_pos, y_pos;
    logic        btn_up, btn_down;
    logic        hsync_out, vsync_out;
    logic [11:0] rgb_out;
    logic [7:0]  score;
    logic        miss;
    logic [9:0]  ball_x, ball_y, paddle_y;

    pong_frame_renderer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .rgb_out    (rgb_out),
        .score      (score),
        .miss       (miss),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_y   (paddle_y)
    );

    always #5 clk = ~clk;

    typedef enum int {K_RGB, K_HS, K_VS, K_BX, K_BY, K_PY, K_SC, K_MISS} kind_e;

    typedef struct {
        int    cyc;
        kind_e kind;
        int    val;
        string name;
    } exp_t;

    typedef struct {
        int    tick;
        int    offs;
        kind_e kind;
        int    val;
    } tvec_t;

    exp_t  sbq[$];
    tvec_t tickVecs[$];
    exp_t  monE;

    int cyc     = 0;
    int nChecks = 0;
    int nPass   = 0;
    int pixNum  = 0;
    logic stimUp, stimDown;

    // Cycle counter: value seen at a negedge is the number of posedges so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kindName(input kind_e k);
        case (k)
            K_RGB:   return "rgb";
            K_HS:    return "hsync";
            K_VS:    return "vsync";
            K_BX:    return "ball_x";
            K_BY:    return "ball_y";
            K_PY:    return "paddle_y";
            K_SC:    return "score";
            default: return "miss";
        endcase
    endfunction

    function automatic int actualOf(input kind_e k);
        case (k)
            K_RGB:   return int'(rgb_out);
            K_HS:    return int'(hsync_out);
            K_VS:    return int'(vsync_out);
            K_BX:    return int'(ball_x);
            K_BY:    return int'(ball_y);
            K_PY:    return int'(paddle_y);
            K_SC:    return int'(score);
            default: return int'(miss);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        nChecks++;
        if (act == req) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    task automatic pushExp(input int c, input kind_e k, input int v, input string n);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = n;
        sbq.push_back(e);
    endtask

    task automatic addTv(input int t, input int o, input kind_e k, input int v);
        tvec_t tv;
        tv.tick = t;
        tv.offs = o;
        tv.kind = k;
        tv.val  = v;
        tickVecs.push_back(tv);
    endtask

    // Hand-computed expectations, indexed by frame tick since reset.
    // Play tick p is tick p+60. Ball path: right wall at p=158 (x=632),
    // bottom at p=118 (y=472), top at p=354 (y=0), paddle face reached at
    // p=462, hit at p=463, second left pass misses at p=1084.
    task automatic buildTickVecs();
        addTv(1, 0, K_BX, 316);   addTv(1, 0, K_BY, 236);
        addTv(1, 0, K_PY, 204);   addTv(1, 0, K_MISS, 0);
        addTv(1, 0, K_VS, 1);     addTv(1, 1, K_VS, 0);   addTv(1, 2, K_VS, 1);
        addTv(51, 0, K_PY, 4);    addTv(52, 0, K_PY, 0);
        addTv(60, 0, K_BX, 316);  addTv(60, 0, K_BY, 236); addTv(60, 0, K_PY, 0);
        addTv(61, 0, K_BX, 318);  addTv(61, 0, K_BY, 238); addTv(61, 0, K_PY, 0);
        addTv(62, 0, K_BX, 320);  addTv(62, 0, K_PY, 0);
        addTv(63, 0, K_PY, 4);    addTv(114, 0, K_PY, 208); addTv(115, 0, K_PY, 208);
        addTv(177, 0, K_BY, 470); addTv(178, 0, K_BY, 472); addTv(178, 0, K_BX, 552);
        addTv(179, 0, K_BY, 470);
        addTv(218, 0, K_BX, 632); addTv(219, 0, K_BX, 630);
        addTv(414, 0, K_BY, 0);   addTv(415, 0, K_BY, 2);
        addTv(522, 0, K_BX, 24);  addTv(522, 0, K_BY, 216); addTv(522, 0, K_SC, 0);
        addTv(523, 0, K_BX, 24);  addTv(523, 0, K_BY, 218); addTv(523, 0, K_SC, 1);
        addTv(523, 0, K_PY, 208); addTv(523, 0, K_MISS, 0);
        addTv(524, 0, K_BX, 26);  addTv(524, 0, K_BY, 220);
        addTv(576, 0, K_PY, 0);   addTv(577, 0, K_PY, 0);
        addTv(1143, 0, K_BX, 0);  addTv(1143, 0, K_BY, 430);
        addTv(1143, 0, K_SC, 1);  addTv(1143, 0, K_MISS, 0);
        addTv(1144, 0, K_BX, 316); addTv(1144, 0, K_BY, 236);
        addTv(1144, 0, K_SC, 0);  addTv(1144, 0, K_MISS, 1); addTv(1144, 1, K_MISS, 0);
        addTv(1145, 0, K_BX, 316); addTv(1145, 0, K_BY, 236);
        addTv(1204, 0, K_BX, 316); addTv(1204, 0, K_BY, 236);
        addTv(1205, 0, K_BX, 318); addTv(1205, 0, K_BY, 234); addTv(1205, 0, K_PY, 0);
    endtask

    task automatic expectTick(input int t, input int tc);
        for (int o = 0; o <= 2; o++) begin
            foreach (tickVecs[i]) begin
                if (tickVecs[i].tick == t && tickVecs[i].offs == o) begin
                    pushExp(tc + o, tickVecs[i].kind, tickVecs[i].val,
                            $sformatf("tick%0d_%s", t, kindName(tickVecs[i].kind)));
                end
            end
        end
    endtask

    // One synthetic frame: set buttons, give the synchronizer time, then a
    // single-cycle vsync low whose falling edge is the frame tick.
    task automatic applyStimulus(input logic up, input logic down, input int t);
        int tc;
        @(negedge clk);
        btn_up   = up;
        btn_down = down;
        repeat (2) @(negedge clk);
        @(negedge clk);
        vsync_in = 1'b0;
        tc = cyc + 1;
        expectTick(t, tc);
        @(negedge clk);
        vsync_in = 1'b1;
    endtask

    task automatic applyPixel(input int x, input int y, input logic de, input logic hs,
                              input int rgbExp, input int hsExp);
        @(negedge clk);
        x_pos      = 10'(x);
        y_pos      = 10'(y);
        display_on = de;
        hsync_in   = hs;
        pushExp(cyc + 2, K_RGB, rgbExp, $sformatf("pix%0d_rgb", pixNum));
        pushExp(cyc + 2, K_HS, hsExp, $sformatf("pix%0d_hsync", pixNum));
        pixNum++;
    endtask

    // Monitor: compares every expectation due on this cycle; anything whose
    // cycle has already passed is reported as overdue.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            monE = sbq.pop_front();
            if (monE.cyc < cyc) begin
                checkOutput({monE.name, "_overdue"}, cyc, monE.cyc);
            end else begin
                checkOutput(monE.name, actualOf(monE.kind), monE.val);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        buildTickVecs();
        rst_n      = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        display_on = 1'b0;
        x_pos      = 10'd0;
        y_pos      = 10'd0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        pushExp(cyc + 1, K_HS, 1, "rst_hsync");
        pushExp(cyc + 1, K_VS, 1, "rst_vsync");
        pushExp(cyc + 1, K_RGB, 0, "rst_rgb");
        pushExp(cyc + 1, K_SC, 0, "rst_score");
        pushExp(cyc + 1, K_MISS, 0, "rst_miss");
        pushExp(cyc + 1, K_BX, 316, "rst_ball_x");
        pushExp(cyc + 1, K_BY, 236, "rst_ball_y");
        pushExp(cyc + 1, K_PY, 208, "rst_paddle_y");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pixel pipeline in SERVE: ball (316,236), paddle x 16..23 y 208..271
        applyPixel(316, 236, 1'b1, 1'b1, 12'hFFF, 1);
        applyPixel(323, 243, 1'b1, 1'b1, 12'hFFF, 1);
        applyPixel(324, 236, 1'b1, 1'b1, 12'h002, 1);
        applyPixel(316, 244, 1'b1, 1'b1, 12'h002, 1);
        applyPixel(315, 236, 1'b1, 1'b1, 12'h002, 1);
        applyPixel(316, 236, 1'b0, 1'b1, 12'h000, 1);
        applyPixel(20,  240, 1'b1, 1'b0, 12'h0F0, 0);
        applyPixel(16,  208, 1'b1, 1'b1, 12'h0F0, 1);
        applyPixel(23,  271, 1'b1, 1'b1, 12'h0F0, 1);
        applyPixel(24,  240, 1'b1, 1'b1, 12'h002, 1);
        applyPixel(20,  272, 1'b1, 1'b1, 12'h002, 1);
        applyPixel(20,  207, 1'b1, 1'b1, 12'h002, 1);
        @(negedge clk);
        display_on = 1'b0;
        hsync_in   = 1'b1;
        repeat (3) @(negedge clk);

        // Game: serve with paddle driven up, both buttons, paddle back down,
        // idle through the hit, paddle moved away, idle through the miss.
        for (int t = 1; t <= 1205; t++) begin
            stimUp   = (t <= 62) || (t >= 525 && t <= 576);
            stimDown = (t >= 61 && t <= 114);
            applyStimulus(stimUp, stimDown, t);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (4) @(negedge clk);

        // Light up the ball pixel with hsync low, then reset between edges
        @(negedge clk);
        x_pos      = 10'd318;
        y_pos      = 10'd234;
        display_on = 1'b1;
        hsync_in   = 1'b0;
        pushExp(cyc + 2, K_RGB, 12'hFFF, "pre_rst_rgb");
        pushExp(cyc + 2, K_HS, 0, "pre_rst_hsync");
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_hsync", int'(hsync_out), 1);
        checkOutput("async_vsync", int'(vsync_out), 1);
        checkOutput("async_rgb", int'(rgb_out), 0);
        checkOutput("async_score", int'(score), 0);
        checkOutput("async_miss", int'(miss), 0);
        checkOutput("async_ball_x", int'(ball_x), 316);
        checkOutput("async_ball_y", int'(ball_y), 236);
        checkOutput("async_paddle_y", int'(paddle_y), 208);

        @(negedge clk);
        checkOutput("sb_drain", sbq.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/pong_frame_renderer.md
# pong_frame_renderer

Pixel-generation and game-state stage placed directly downstream of the 640x480 VGA timing generator. It consumes the generator's hsync/vsync, display_on and x_pos/y_pos and updates one ball and one player paddle once per frame during vertical blanking. It emits 12-bit RGB with sync outputs delayed so they stay aligned to the pixels. The generator's own timing is not modified.

## Interface
- H_DISPLAY, 640: active width in pixels
- V_DISPLAY, 480: active height in lines
- BALL_SIZE, 8: ball edge length in pixels (square)
- PAD_X, 16: paddle left edge x
- PAD_W, 8: paddle width
- PAD_H, 64: paddle height
- PAD_SPEED, 4: paddle pixels per frame
- BALL_SPEED, 2: ball pixels per frame on each axis
- SERVE_FRAMES, 60: frames the ball is held at centre before play
- clk  in  1  pixel clock, same clock as the timing generator
- rst_n  in  1  asynchronous, active-low reset
- hsync_in, vsync_in  in  1  active-low syncs from the timing generator
- display_on  in  1  active-video flag
- x_pos, y_pos  in  10  current pixel coordinates
- btn_up, btn_down  in  1  asynchronous buttons, active-high
- hsync_out, vsync_out  out  1  syncs delayed 2 cycles
- rgb_out  out  12  {R[3:0],G[3:0],B[3:0]}, delayed 2 cycles
- score  out  8  paddle hits since last miss, saturates at 255
- miss  out  1  one-cycle pulse when the ball passes the left edge
- ball_x, ball_y, paddle_y  out  10  current object positions (top-left corner)

## Operation
- Buttons pass through a 2-flop synchronizer; the reset value is 0.
- vs_d is a register on vsync_in with reset value 1. frame_tick = vs_d & ~vsync_in. Only falling edges produce a tick, and the tick lands in vertical blanking.
- All state below updates only on a clk edge where frame_tick = 1.
- Paddle movement:
  - Synchronized up only: paddle_y -= PAD_SPEED, saturating at 0.
  - Synchronized down only: paddle_y += PAD_SPEED, saturating at V_DISPLAY-PAD_H.
  - Both or neither: no move.
  - The paddle moves in both FSM states.
- FSM SERVE: ball frozen. serve_cnt increments each tick; on the tick where serve_cnt = SERVE_FRAMES-1, go to PLAY and clear serve_cnt.
- FSM PLAY, x axis with dx=1 (moving right):
  - nx = ball_x + BALL_SPEED.
  - If nx >= H_DISPLAY-BALL_SIZE: ball_x = H_DISPLAY-BALL_SIZE and dx = 0.
  - Otherwise ball_x = nx.
- FSM PLAY, x axis with dx=0, where P = PAD_X+PAD_W:
  - If ball_x >= P+BALL_SPEED: ball_x -= BALL_SPEED.
  - Else, if ball_x >= P and the ball overlaps the paddle vertically (ball_y+BALL_SIZE > paddle_y and ball_y < paddle_y+PAD_H): paddle hit. ball_x = P, dx = 1, score +1 saturating.
  - Else, if ball_x >= BALL_SPEED: ball_x -= BALL_SPEED.
  - Else: miss. miss = 1 for that cycle, score = 0, ball returns to centre (316,236), dx = 1, dy unchanged, state goes to SERVE.
- FSM PLAY, y axis with dy=1 (moving down): if ball_y+BALL_SPEED >= V_DISPLAY-BALL_SIZE, then ball_y = V_DISPLAY-BALL_SIZE and dy = 0. Otherwise ball_y += BALL_SPEED.
- FSM PLAY, y axis with dy=0 (moving up): if ball_y <= BALL_SPEED, then ball_y = 0 and dy = 1. Otherwise ball_y -= BALL_SPEED.
- The x and y axes update on the same tick, so a corner reflects both directions.
- All comparisons use 11-bit intermediates so no unsigned wrap occurs.
- Pixel pipeline stage 1: register x_pos, y_pos, display_on and both syncs.
- Pixel pipeline stage 2: compute the colour from the stage-1 values and register rgb_out and the syncs.
  - Colour priority: !display_on gives 000; inside the ball gives FFF; inside the paddle gives 0F0; anything else gives 002.
  - "Inside" is a half-open range on both axes, e.g. ball_x <= x < ball_x+BALL_SIZE.

## Timing
- Reset values:
  - Outputs: hsync_out = 1, vsync_out = 1, rgb_out = 0, score = 0, miss = 0, ball_x = 316, ball_y = 236, paddle_y = 208.
  - Internal state: dx = 1, dy = 1, state SERVE, serve_cnt = 0, all pipeline registers 0 except the sync registers, which reset to 1.
- Pixel-to-RGB latency is exactly 2 cycles; sync outputs carry the same 2-cycle delay.
- Button-to-paddle latency: 2 sync cycles, then the next frame_tick.
- Positions change during vertical blanking only, so no tearing within a frame.
- An rst_n assertion at any point, mid-line or mid-frame, forces all reset values immediately. Release is synchronous to clk.

## Test plan
- Reset and serve:
  - Stimulus: release reset, then generate 60 vsync falling edges.
  - Required: ball stays at (316,236) through tick 60, and state is PLAY after tick 60. Tick 61 moves the ball to (318,238).
- Pixel pipeline:
  - Stimulus: drive x=316, y=236, display_on=1 in SERVE.
  - Required: rgb_out = FFF exactly 2 cycles later. display_on=0 gives 000; x=20, y=240 gives 0F0. An hsync_in toggle appears on hsync_out 2 cycles later.
- Paddle saturation:
  - Stimulus: hold btn_up for 60 frames, then press both buttons.
  - Required: paddle_y reaches 0 after 52 ticks and stays at 0. With both buttons pressed, no move.
- Bottom bounce:
  - Stimulus: from reset, idle the buttons.
  - Required: on PLAY tick 118, ball_y = 472 and dy flips. On tick 119, ball_y = 470.
- Paddle hit and miss:
  - Stimulus: steer the paddle to intercept the ball at the paddle plane; on a later pass, move the paddle away.
  - Required: on the intercept tick, ball_x = 24, dx = 1, score = 1. On the missed pass, the miss pulse is 1 cycle, score = 0, ball = (316,236), state is SERVE.
- Async reset mid-frame:
  - Stimulus: assert rst_n low mid-line during PLAY, before release.
  - Required: all outputs take their reset values without a clk edge.
